// File: rtl/ov_sccb_init_seq.sv
// Camera init sequencer: walks a {subaddr,data} ROM table once per camera and drives an SCCB master.
// Optional macro OV_SEQ_READBACK_EN adds a read-back compare after every register write.
module ov_sccb_init_seq #(
   parameter int         ROM_AW      = 8,
   parameter logic [7:0] DEV_ADDR    = 8'h42,
   parameter int         DELAY_UNIT  = 1000,
   parameter int         ACK_TIMEOUT = 4095
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init_req,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              sccb_start,
   input  logic              sccb_busy,
   input  logic              sccb_done,
   output logic [7:0]        sccb_addr,
   output logic [7:0]        sccb_subaddr,
   output logic [7:0]        sccb_wdata,
   input  logic [7:0]        sccb_rdata,
   output logic              cam_sel,
   output logic              init_busy,
   output logic              init_done,
   output logic              init_err
);

   // state        | meaning
   // IDLE         | waiting for init_req with the master idle
   // FETCH        | ROM address presented, data arrives next cycle
   // DECODE       | classify entry: end, delay or register write
   // ISSUE        | sccb_start high for this one cycle
   // WAIT_ACK     | waiting for master busy, timeout counter running
   // WAIT_DONE    | waiting for master done
   // DELAY        | down-counting nn*DELAY_UNIT cycles
   // NEXT_CAM     | switch to the right camera or finish
   // DONE         | one cycle: publish init_done, drop init_busy
   // RB_ISSUE     | read-back start pulse (readback build only)
   // RB_WAIT_ACK  | read-back waiting for busy
   // RB_WAIT_DONE | read-back waiting for done, then compare

   localparam int DLY_MAX = 255 * DELAY_UNIT;
   localparam int CNT_MAX = (DLY_MAX > ACK_TIMEOUT) ? DLY_MAX : ACK_TIMEOUT;
   localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 20) ? $clog2(CNT_MAX + 1) : 20;

   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] UNIT       = CNT_W'(DELAY_UNIT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [7:0]       WR_ADDR    = DEV_ADDR & 8'hFE;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      DELAY,
      NEXT_CAM,
      DONE,
      RB_ISSUE,
      RB_WAIT_ACK,
      RB_WAIT_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic             is_end;
   logic             is_delay;
   logic             last_addr;
   logic [CNT_W-1:0] dly_ld;

   assign is_end    = (rom_data == 16'hFFFF);
   assign is_delay  = (rom_data[15:8] == 8'hF0);
   assign last_addr = &rom_addr;
   assign dly_ld    = CNT_W'(rom_data[7:0]) * UNIT;

`ifdef OV_SEQ_READBACK_EN
   localparam logic [7:0] RD_ADDR = DEV_ADDR | 8'h01;
`else
   logic unused_rdata;
   assign unused_rdata = ^sccb_rdata;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         rom_addr     <= '0;
         sccb_start   <= 1'b0;
         sccb_addr    <= WR_ADDR;
         sccb_subaddr <= 8'h00;
         sccb_wdata   <= 8'h00;
         cam_sel      <= 1'b0;
         init_busy    <= 1'b0;
         init_done    <= 1'b0;
         init_err     <= 1'b0;
      end else begin
         sccb_start <= 1'b0;
         case (state)
            IDLE: begin
               if (init_req && sccb_done) begin
                  rom_addr  <= '0;
                  cam_sel   <= 1'b0;
                  init_busy <= 1'b1;
                  init_done <= 1'b0;
                  init_err  <= 1'b0;
                  state     <= FETCH;
               end
            end
            FETCH: state <= DECODE;
            DECODE: begin
               if (is_end) begin
                  state <= NEXT_CAM;
               end else if (is_delay) begin
                  cnt   <= dly_ld;
                  state <= DELAY;
               end else begin
                  sccb_addr    <= WR_ADDR;
                  sccb_subaddr <= rom_data[15:8];
                  sccb_wdata   <= rom_data[7:0];
                  sccb_start   <= 1'b1;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= TIMEOUT_LD;
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (sccb_busy) begin
                  state <= WAIT_DONE;
               end else if (cnt == '0) begin
                  init_err <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            WAIT_DONE: begin
               if (sccb_done) begin
`ifdef OV_SEQ_READBACK_EN
                  sccb_addr  <= RD_ADDR;
                  sccb_start <= 1'b1;
                  state      <= RB_ISSUE;
`else
                  // Running off the top of the table counts as an end entry.
                  if (last_addr) begin
                     state <= NEXT_CAM;
                  end else begin
                     rom_addr <= rom_addr + ROM_AW'(1);
                     state    <= FETCH;
                  end
`endif
               end
            end
            DELAY: begin
               // nn=0 loads zero and leaves after a single cycle.
               if (cnt <= CNT_ONE) begin
                  cnt <= '0;
                  if (last_addr) begin
                     state <= NEXT_CAM;
                  end else begin
                     rom_addr <= rom_addr + ROM_AW'(1);
                     state    <= FETCH;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            NEXT_CAM: begin
               if (!cam_sel) begin
                  cam_sel  <= 1'b1;
                  rom_addr <= '0;
                  state    <= FETCH;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               init_done <= !init_err;
               init_busy <= 1'b0;
               sccb_addr <= WR_ADDR;
               cnt       <= '0;
               state     <= IDLE;
            end
`ifdef OV_SEQ_READBACK_EN
            RB_ISSUE: begin
               cnt   <= TIMEOUT_LD;
               state <= RB_WAIT_ACK;
            end
            RB_WAIT_ACK: begin
               if (sccb_busy) begin
                  state <= RB_WAIT_DONE;
               end else if (cnt == '0) begin
                  init_err <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            RB_WAIT_DONE: begin
               if (sccb_done) begin
                  if (sccb_rdata != sccb_wdata) init_err <= 1'b1;
                  sccb_addr <= WR_ADDR;
                  if (last_addr) begin
                     state <= NEXT_CAM;
                  end else begin
                     rom_addr <= rom_addr + ROM_AW'(1);
                     state    <= FETCH;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov_sccb_init_seq.sv
// Scoreboard bench for ov_sccb_init_seq: ROM and SCCB master models, expected starts queued per pass.
module tb_ov_sccb_init_seq;

   localparam int DELAY_UNIT  = 10;
   localparam int ACK_TIMEOUT = 40;
   localparam int ACK_LAT     = 3;
   localparam int DONE_LAT    = 20;
`ifdef OV_SEQ_READBACK_EN
   localparam int PER_W = 2;
`else
   localparam int PER_W = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        init_req = 1'b0;
   logic [7:0]  rom_addr;
   logic [15:0] rom_data = 16'h0000;
   logic        sccb_start;
   logic        sccb_busy = 1'b0;
   logic        sccb_done = 1'b1;
   logic [7:0]  sccb_addr;
   logic [7:0]  sccb_subaddr;
   logic [7:0]  sccb_wdata;
   logic [7:0]  sccb_rdata = 8'h00;
   logic        cam_sel;
   logic        init_busy;
   logic        init_done;
   logic        init_err;

   always #5 clk = ~clk;

   ov_sccb_init_seq #(
      .ROM_AW(8), .DEV_ADDR(8'h42), .DELAY_UNIT(DELAY_UNIT), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .init_req(init_req), .rom_addr(rom_addr), .rom_data(rom_data),
      .sccb_start(sccb_start), .sccb_busy(sccb_busy), .sccb_done(sccb_done),
      .sccb_addr(sccb_addr), .sccb_subaddr(sccb_subaddr), .sccb_wdata(sccb_wdata),
      .sccb_rdata(sccb_rdata), .cam_sel(cam_sel), .init_busy(init_busy),
      .init_done(init_done), .init_err(init_err)
   );

   logic [15:0] rom [256];
   always @(posedge clk) rom_data <= rom[rom_addr];

   // Master model: busy ACK_LAT cycles after start, done DONE_LAT cycles after start.
   logic       no_busy = 1'b0;
   logic       corrupt = 1'b0;
   logic       active = 1'b0;
   int         tmr = 0;
   logic [7:0] m_addr, m_sub, m_wd;
   logic [7:0] mem [256];

   always @(posedge clk) begin
      if (reset) begin
         sccb_busy <= 1'b0;
         sccb_done <= 1'b1;
         active    <= 1'b0;
         tmr       <= 0;
      end else if (!active) begin
         if (sccb_start && !no_busy) begin
            active    <= 1'b1;
            tmr       <= 0;
            sccb_done <= 1'b0;
            m_addr    <= sccb_addr;
            m_sub     <= sccb_subaddr;
            m_wd      <= sccb_wdata;
         end
      end else begin
         tmr <= tmr + 1;
         if (tmr == ACK_LAT - 1) sccb_busy <= 1'b1;
         if (tmr == DONE_LAT - 1) begin
            sccb_busy <= 1'b0;
            sccb_done <= 1'b1;
            active    <= 1'b0;
            if (m_addr[0]) sccb_rdata <= (corrupt && mem[m_sub] == 8'h55) ? 8'h54 : mem[m_sub];
            else           mem[m_sub] <= m_wd;
         end
      end
   end

   typedef struct packed {
      logic       cam;
      logic [7:0] addr;
      logic [7:0] sub;
      logic [7:0] wd;
   } txn_t;

   txn_t exp_q [$];
   int   errors = 0;
   int   checks = 0;
   int   starts = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sccb_start) begin
         txn_t e;
         starts++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got start sub=%0h addr=%0h expected none", sccb_subaddr, sccb_addr);
         end else begin
            e = exp_q.pop_front();
            check("start_cam",  {31'd0, cam_sel}, {31'd0, e.cam});
            check("start_addr", {24'd0, sccb_addr}, {24'd0, e.addr});
            check("start_sub",  {24'd0, sccb_subaddr}, {24'd0, e.sub});
            check("start_wd",   {24'd0, sccb_wdata}, {24'd0, e.wd});
         end
      end
   end

   task automatic push_write(input logic cam, input logic [7:0] sub, input logic [7:0] wd);
      txn_t t;
      t.cam = cam; t.addr = 8'h42; t.sub = sub; t.wd = wd;
      exp_q.push_back(t);
`ifdef OV_SEQ_READBACK_EN
      t.addr = 8'h43;
      exp_q.push_back(t);
`endif
   endtask

   task automatic load_std();
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      rom[0] = 16'h1280;
      rom[1] = 16'h0A55;
   endtask

   task automatic push_std();
      for (int c = 0; c < 2; c++) begin
         push_write(c[0], 8'h12, 8'h80);
         push_write(c[0], 8'h0A, 8'h55);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rom_addr"}, {24'd0, rom_addr}, 32'h0);
      check({tag, "_start"}, {31'd0, sccb_start}, 32'h0);
      check({tag, "_addr"}, {24'd0, sccb_addr}, 32'h42);
      check({tag, "_sub"}, {24'd0, sccb_subaddr}, 32'h0);
      check({tag, "_wdata"}, {24'd0, sccb_wdata}, 32'h0);
      check({tag, "_cam"}, {31'd0, cam_sel}, 32'h0);
      check({tag, "_busy"}, {31'd0, init_busy}, 32'h0);
      check({tag, "_done"}, {31'd0, init_done}, 32'h0);
      check({tag, "_err"}, {31'd0, init_err}, 32'h0);
   endtask

   task automatic run_pass(input int bound, output int busy_cyc);
      int n;
      @(negedge clk) init_req = 1'b1;
      @(negedge clk) init_req = 1'b0;
      check("pass_started", {31'd0, init_busy}, 32'h1);
      check("pass_err_cleared", {31'd0, init_err}, 32'h0);
      busy_cyc = 0;
      n = 0;
      while (init_busy && n < bound) begin
         busy_cyc++;
         n++;
         @(negedge clk);
      end
      check("pass_ended_in_bound", {31'd0, init_busy}, 32'h0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc, n, s0;

      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Two writes per camera with a well-behaved master.
      load_std();
      push_std();
      s0 = starts;
      run_pass(2000, bc);
      check("std_done", {31'd0, init_done}, 32'h1);
      check("std_err", {31'd0, init_err}, 32'h0);
      check("std_starts", starts - s0, 4 * PER_W);
      check("std_q_empty", exp_q.size(), 0);

      // Delay entry F002 with DELAY_UNIT=10: 20-cycle wait per camera, no writes.
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      rom[0] = 16'hF002;
      s0 = starts;
      run_pass(500, bc);
      check("dly_busy_cycles", bc, 51);
      check("dly_done", {31'd0, init_done}, 32'h1);
      check("dly_starts", starts - s0, 0);

      // No end entry anywhere: address wrap ends each camera's table.
      for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
      s0 = starts;
      run_pass(5000, bc);
      check("wrap_done", {31'd0, init_done}, 32'h1);
      check("wrap_err", {31'd0, init_err}, 32'h0);
      check("wrap_starts", starts - s0, 0);

      // Master never goes busy: timeout after ACK_TIMEOUT+1 waiting cycles.
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
      rom[0] = 16'h1280;
      begin
         txn_t t;
         t.cam = 1'b0; t.addr = 8'h42; t.sub = 8'h12; t.wd = 8'h80;
         exp_q.push_back(t);
      end
      no_busy = 1'b1;
      @(negedge clk) init_req = 1'b1;
      @(negedge clk) init_req = 1'b0;
      n = 0;
      while (!sccb_start && n < 50) begin @(negedge clk); n++; end
      check("to_start_seen", {31'd0, sccb_start}, 32'h1);
      @(negedge clk);
      n = 0;
      while (!init_err && n < 200) begin n++; @(negedge clk); end
      check("to_cycles", n, ACK_TIMEOUT + 1);
      @(negedge clk);
      check("to_busy_fell", {31'd0, init_busy}, 32'h0);
      check("to_done", {31'd0, init_done}, 32'h0);
      check("to_err_sticky", {31'd0, init_err}, 32'h1);
      check("to_q_empty", exp_q.size(), 0);
      no_busy = 1'b0;
      repeat (3) @(negedge clk);

      // Reset during WAIT_DONE of the second write.
      load_std();
      push_write(1'b0, 8'h12, 8'h80);
      begin
         txn_t t;
         t.cam = 1'b0; t.addr = 8'h42; t.sub = 8'h0A; t.wd = 8'h55;
         exp_q.push_back(t);
      end
      s0 = starts;
      @(negedge clk) init_req = 1'b1;
      @(negedge clk) init_req = 1'b0;
      check("rst_err_cleared", {31'd0, init_err}, 32'h0);
      n = 0;
      while (starts < s0 + PER_W + 1 && n < 300) begin @(negedge clk); n++; end
      check("rst_second_write_seen", starts - s0, PER_W + 1);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("midrst");
      reset = 1'b0;
      repeat (60) @(negedge clk);
      check("rst_no_start", starts - s0, PER_W + 1);
      check("rst_q_empty", exp_q.size(), 0);
      push_std();
      s0 = starts;
      run_pass(2000, bc);
      check("rst_rerun_done", {31'd0, init_done}, 32'h1);
      check("rst_rerun_starts", starts - s0, 4 * PER_W);

      // init_req held through a pass: one pass only, init_done cleared at its start.
      push_std();
      s0 = starts;
      @(negedge clk) init_req = 1'b1;
      @(negedge clk);
      check("held_busy", {31'd0, init_busy}, 32'h1);
      check("held_done_cleared", {31'd0, init_done}, 32'h0);
      n = 0;
      while (!init_done && n < 2000) begin @(negedge clk); n++; end
      init_req = 1'b0;
      check("held_done", {31'd0, init_done}, 32'h1);
      repeat (40) @(negedge clk);
      check("held_idle", {31'd0, init_busy}, 32'h0);
      check("held_starts", starts - s0, 4 * PER_W);
      check("held_q_empty", exp_q.size(), 0);

`ifdef OV_SEQ_READBACK_EN
      // Read-back returns 54 for a written 55: error flagged, both cameras still done.
      corrupt = 1'b1;
      push_std();
      s0 = starts;
      run_pass(3000, bc);
      check("rb_err", {31'd0, init_err}, 32'h1);
      check("rb_done", {31'd0, init_done}, 32'h0);
      check("rb_starts", starts - s0, 8);
      check("rb_q_empty", exp_q.size(), 0);
      corrupt = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
